// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage ASIP pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle ops.
// Also handles external halt/resume and keeps a saturating stall counter.
module pipeline_ctrl #(
  parameter int N          = 32,
  parameter int RA         = 4,
  parameter int MC_TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [RA-1:0] rs1_id,
  input  logic [RA-1:0] rs2_id,
  input  logic [RA-1:0] rd_ex,
  input  logic          memread_ex,
  input  logic          branch_taken_ex,
  input  logic          mc_op_ex,
  input  logic          mc_done,
  input  logic          halt_req,
  input  logic          resume,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_en,
  output logic          ex_mem_en,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          ex_mem_flush,
  output logic          mc_start,
  output logic          halted,
  output logic          mc_error,
  output logic [N-1:0]  stall_cycles
);

  localparam int CW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   mc_cnt_reg, mc_cnt_next;
  logic            mc_error_reg, mc_error_next;
  logic [N-1:0]    stall_cycles_reg;

  // Load-use detection: compare the EX destination against each ID source.
  logic [RA-1:0]   src_reg [2];
  logic [1:0]      src_hit;
  logic            load_use;

  assign src_reg[0] = rs1_id;
  assign src_reg[1] = rs2_id;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = (rd_ex == src_reg[gi]);
    end
  endgenerate

  // Register 0 is hardwired, so a load into it never creates a hazard.
  assign load_use = memread_ex && (rd_ex != '0) && (|src_hit);

  // State, timeout counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      mc_cnt_reg   <= '0;
      mc_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mc_cnt_reg   <= mc_cnt_next;
      mc_error_reg <= mc_error_next;
    end
  end

  // Next-state and enable/flush decode; reset forces every stage to load a bubble.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mc_start      = 1'b0;
    state_next    = state_reg;
    mc_cnt_next   = mc_cnt_reg;
    mc_error_next = mc_error_reg;

    case (state_reg)
      ST_RUN: begin
        if (branch_taken_ex) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (mc_op_ex) begin
          mc_start     = 1'b1;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          ex_mem_flush = 1'b1;
          mc_cnt_next  = '0;
          state_next   = ST_MC_WAIT;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (halt_req) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          id_ex_en   = 1'b0;
          ex_mem_en  = 1'b0;
          state_next = ST_HALT;
        end
      end

      ST_MC_WAIT: begin
        mc_cnt_next = mc_cnt_reg + CW'(1);
        if (mc_done) begin
          // Result is captured into EX/MEM with everything advancing.
          state_next = ST_RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          if (mc_cnt_reg == CW'(MC_TIMEOUT - 1)) begin
            mc_error_next = 1'b1;
            state_next    = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        if (resume && !mc_error_reg) begin
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mc_start     = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (!pc_en && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + N'(1);
    end
  end

  assign halted       = (state_reg == ST_HALT) && !reset;
  assign mc_error     = mc_error_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: vector table, directed multi-cycle sequences
// and random stimulus checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       memread_ex = 0, branch_taken_ex = 0, mc_op_ex = 0;
  logic       mc_done = 0, halt_req = 0, resume = 0;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mc_start, halted, mc_error;
  logic [31:0] stall_cycles;

  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mc_start, s_halted, s_mc_error;
  logic [3:0] s_stall_cycles;

  always #5 clock = ~clock;

  pipeline_ctrl #(.N(32), .RA(4), .MC_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .mc_op_ex(mc_op_ex), .mc_done(mc_done), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mc_start(mc_start), .halted(halted), .mc_error(mc_error),
    .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  pipeline_ctrl #(.N(4), .RA(4), .MC_TIMEOUT(TO)) dut_sat (
    .clock(clock), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
    .mc_op_ex(mc_op_ex), .mc_done(mc_done), .halt_req(halt_req), .resume(resume),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
    .mc_start(s_mc_start), .halted(s_halted), .mc_error(s_mc_error),
    .stall_cycles(s_stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;
  int n_mcstart = 0;

  // Behavioural model: frozen/halted flags, waited-cycle tally, stall total.
  bit     m_wait, m_halt, m_err;
  int     m_waited;
  longint m_stalls;

  logic [7:0]  last_outs;
  logic        last_halted, last_err;
  logic [31:0] last_stall;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (step %0d)", nm, act, exp, n_step);
    end
  endtask

  task automatic model_clear();
    m_wait = 0; m_halt = 0; m_err = 0; m_waited = 0; m_stalls = 0;
  endtask

  // One clock cycle: drive on the falling edge, sample 1ns later, model advances on the rising edge.
  task automatic step(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rdv,
                      input logic mr, input logic br, input logic mc, input logic dn,
                      input logic hr, input logic rs, input logic rst);
    logic [7:0] e;
    logic       lu;
    longint     sat;
    @(negedge clock);
    rs1_id = r1; rs2_id = r2; rd_ex = rdv; memread_ex = mr; branch_taken_ex = br;
    mc_op_ex = mc; mc_done = dn; halt_req = hr; resume = rs; reset = rst;
    if (rst) model_clear();
    #1;
    lu = mr && (rdv != 4'd0) && (rdv == r1 || rdv == r2);
    if (rst)        e = 8'b0000_1110;
    else if (m_halt) e = 8'b0000_0000;
    else if (m_wait) e = dn ? 8'b1111_0000 : 8'b0001_0010;
    else if (br)     e = 8'b1111_1100;
    else if (mc)     e = 8'b0000_0011;
    else if (lu)     e = 8'b0011_0100;
    else if (hr)     e = 8'b0000_0000;
    else             e = 8'b1111_0000;
    last_outs   = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush, mc_start};
    last_halted = halted;
    last_err    = mc_error;
    last_stall  = stall_cycles;
    if (mc_start) n_mcstart++;
    sat = (m_stalls > 15) ? 15 : m_stalls;
    $display("step %0d rst=%0b rs1=%0d rs2=%0d rd=%0d mr=%0b br=%0b mc=%0b dn=%0b hr=%0b rs=%0b outs=%b exp=%b halted=%0b err=%0b stalls=%0d",
             n_step, rst, r1, r2, rdv, mr, br, mc, dn, hr, rs, last_outs, e, halted, mc_error, stall_cycles);
    check("outs", 64'(last_outs), 64'(e));
    check("halted", 64'(halted), 64'(!rst && m_halt));
    check("mc_error", 64'(mc_error), 64'(m_err));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    check("stall_sat", 64'(s_stall_cycles), 64'(sat));
    @(posedge clock);
    n_step++;
    if (!rst) begin
      if (!e[7] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_halt) begin
        if (rs && !m_err) m_halt = 0;
      end else if (m_wait) begin
        if (dn) m_wait = 0;
        else if (m_waited + 1 == TO) begin
          m_err = 1; m_wait = 0; m_halt = 1;
        end else m_waited++;
      end else if (br) begin
      end else if (mc) begin
        m_wait = 1; m_waited = 0;
      end else if (lu) begin
      end else if (hr) m_halt = 1;
    end
  endtask

  task automatic idle();
    step(4'd1, 4'd2, 4'd5, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  typedef struct {
    logic [3:0] rs1, rs2, rd;
    logic       mr, br, mc, hr;
    logic [7:0] outs;      // {pc,if_id,id_ex,ex_mem en, if_id,id_ex,ex_mem flush, mc_start}
    logic       halt_next;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{4'd1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1111_0000, 1'b0};
    vecs[1]  = '{4'd1, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0011_0100, 1'b0};
    vecs[2]  = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0011_0100, 1'b0};
    vecs[3]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1111_0000, 1'b0};
    vecs[4]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1111_1100, 1'b0};
    vecs[5]  = '{4'd1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1111_1100, 1'b0};
    vecs[6]  = '{4'd1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0011, 1'b0};
    vecs[7]  = '{4'd1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1111_1100, 1'b0};
    vecs[8]  = '{4'd3, 4'd2, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0000_0011, 1'b0};
    vecs[9]  = '{4'd1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0000, 1'b1};
    vecs[10] = '{4'd3, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0011_0100, 1'b0};
    vecs[11] = '{4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1111_0000, 1'b0};
    vecs[12] = '{4'd5, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1111_0000, 1'b0};
    vecs[13] = '{4'd1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'b1111_1100, 1'b0};

    model_clear();

    // Table-driven single-cycle decode from a fresh RUN state.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      step(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].mc,
           1'b0, vecs[i].hr, 1'b0, 1'b0);
      check("tbl_outs", 64'(last_outs), 64'(vecs[i].outs));
      idle();
      check("tbl_halt_next", 64'(last_halted), 64'(vecs[i].halt_next));
    end

    // Load-use: exactly one stall cycle.
    do_reset();
    step(4'd1, 4'd3, 4'd3, 1, 0, 0, 0, 0, 0, 0);
    idle();
    check("lu_stall_count", 64'(last_stall), 64'd1);
    check("lu_resumes", 64'(last_outs[7]), 64'd1);

    // Multi-cycle op finishing after five waiting cycles.
    do_reset();
    n_mcstart = 0;
    step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(4'd1, 4'd2, 4'd5, 0, 1, 1, 0, 1, 0, 0);
    step(4'd1, 4'd2, 4'd5, 0, 0, 1, 1, 0, 0, 0);
    idle();
    check("mc_frozen_cycles", 64'(last_stall), 64'd6);
    check("mc_start_pulses", 64'(n_mcstart), 64'd1);
    check("mc_back_to_run", 64'(last_outs), 64'(8'b1111_0000));

    // Timeout: error and halt after TO waiting cycles; resume ignored.
    do_reset();
    step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < TO; k++) step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 0);
    idle();
    check("to_halted", 64'(last_halted), 64'd1);
    check("to_error", 64'(last_err), 64'd1);
    step(4'd1, 4'd2, 4'd5, 0, 0, 0, 0, 0, 1, 0);
    idle();
    check("to_resume_ignored", 64'(last_halted), 64'd1);

    // Halt then resume.
    do_reset();
    step(4'd1, 4'd2, 4'd5, 0, 0, 0, 0, 1, 0, 0);
    step(4'd1, 4'd2, 4'd5, 0, 0, 0, 0, 1, 0, 0);
    check("halt_halted", 64'(last_halted), 64'd1);
    check("halt_frozen", 64'(last_outs), 64'd0);
    step(4'd1, 4'd2, 4'd5, 0, 0, 0, 0, 0, 1, 0);
    idle();
    check("resume_run", 64'(last_halted), 64'd0);
    check("resume_en", 64'(last_outs), 64'(8'b1111_0000));

    // Reset asserted mid-wait, between clock edges.
    do_reset();
    step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 0);
    step(4'd1, 4'd2, 4'd5, 0, 0, 1, 0, 0, 0, 1);
    check("rst_outs", 64'(last_outs), 64'(8'b0000_1110));
    check("rst_stall", 64'(last_stall), 64'd0);
    check("rst_err", 64'(last_err), 64'd0);
    idle();
    check("rst_run", 64'(last_outs), 64'(8'b1111_0000));

    // Random stimulus against the model.
    for (int k = 0; k < 1500; k++) begin
      logic rst;
      rst = ($urandom_range(0, 49) == 0) || (m_err && $urandom_range(0, 9) == 0);
      step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0), rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
